// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default sizes, counter constants,
// GHR update encoding and saturating counter helpers.
package bp_pkg;

    localparam int unsigned DEF_IDX_W  = 3;
    localparam int unsigned DEF_CTR_W  = 2;
    localparam int unsigned DEF_HIST_W = 3;

    // Two-bit counter midpoints
    localparam logic [DEF_CTR_W-1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [DEF_CTR_W-1:0] CTR_WEAK_T  = 2'b10;

    // Which source the next GHR value comes from
    typedef enum logic [1:0] {
        GhrHold,
        GhrShift,
        GhrRepair
    } ghr_op_e;

    // Increment, sticking at max_val
    function automatic logic [31:0] ctr_sat_inc(input logic [31:0] val,
                                                input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

    // Decrement, sticking at zero
    function automatic logic [31:0] ctr_sat_dec(input logic [31:0] val);
        return (val == 32'd0) ? 32'd0 : val - 32'd1;
    endfunction

endpackage

// File: rtl/bp_ghr.sv
// Speculative global history register. Fetch shifts in its prediction; a
// mispredict in Execute rebuilds history from the snapshot taken at lookup,
// overriding any same-edge Fetch shift because that Fetch is flushed.
module bp_ghr
    import bp_pkg::*;
#(
    parameter int unsigned HIST_W = DEF_HIST_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              shift_bit,
    input  logic              repair_en,
    input  logic [HIST_W-1:0] repair_snap,
    input  logic              repair_bit,
    output logic [HIST_W-1:0] ghr
);

    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;
    ghr_op_e           op;

    // Concatenate then drop the oldest bit; also correct for HIST_W = 1
    logic [HIST_W:0] shift_cat;
    logic [HIST_W:0] repair_cat;

    assign shift_cat  = {ghr_q, shift_bit};
    assign repair_cat = {repair_snap, repair_bit};

    // Pick the update source by priority and form the next history
    always_comb begin
        op    = GhrHold;
        ghr_d = ghr_q;
        if (repair_en) begin
            op = GhrRepair;
        end else if (shift_en) begin
            op = GhrShift;
        end
        unique case (op)
            GhrRepair: ghr_d = repair_cat[HIST_W-1:0];
            GhrShift:  ghr_d = shift_cat[HIST_W-1:0];
            default:   ghr_d = ghr_q;
        endcase
    end

    // History register, updated on the falling edge
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr = ghr_q;

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: saturating counters indexed by PC xor global
// history. Lookup is combinational in Fetch; training, history update and
// mispredict statistics happen on the falling edge from Execute resolution.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = DEF_IDX_W,
    parameter int unsigned CTR_W    = DEF_CTR_W,
    parameter int unsigned HIST_W   = DEF_HIST_W,
    parameter int unsigned INIT_CTR = 32'(CTR_WEAK_NT),
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  lookupPcF,
    input  logic              lookupValidF,
    output logic              predictTakenF,
    output logic [IDX_W-1:0]  lookupIdxF,
    output logic [HIST_W-1:0] ghrSnapF,
    input  logic              updateValidE,
    input  logic [IDX_W-1:0]  updateIdxE,
    input  logic [HIST_W-1:0] ghrSnapE,
    input  logic              branchTakenE,
    input  logic              branchPredictedE,
    output logic              mispredictE,
    output logic [CNT_W-1:0]  mispredCount
);

    localparam int unsigned       ENTRIES  = 1 << IDX_W;
    localparam logic [31:0]       CTR_MAX  = 32'((64'd1 << CTR_W) - 64'd1);
    localparam logic [CTR_W-1:0]  INIT_VAL = CTR_W'(INIT_CTR);

    if (HIST_W > IDX_W || HIST_W < 1 || CTR_W < 1) begin : g_bad_param
        $fatal(1, "gshare_pht: illegal parameters (need 1 <= HIST_W <= IDX_W, CTR_W >= 1)");
    end

    logic [HIST_W-1:0] ghr;
    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_upd;
    logic [CNT_W-1:0]  mispred_cnt_q;

    // Fetch-side lookup; history is zero-extended when shorter than the index
    assign lookupIdxF    = lookupPcF ^ IDX_W'(ghr);
    assign predictTakenF = ctr_q[lookupIdxF][CTR_W-1];
    assign ghrSnapF      = ghr;

    assign mispredictE = updateValidE & (branchTakenE ^ branchPredictedE);

    bp_ghr #(
        .HIST_W (HIST_W)
    ) u_ghr (
        .clk         (clk),
        .reset       (reset),
        .shift_en    (lookupValidF),
        .shift_bit   (predictTakenF),
        .repair_en   (mispredictE),
        .repair_snap (ghrSnapE),
        .repair_bit  (branchTakenE),
        .ghr         (ghr)
    );

    // New value for the entry being trained
    always_comb begin
        ctr_upd = ctr_q[updateIdxE];
        if (branchTakenE) begin
            ctr_upd = CTR_W'(ctr_sat_inc(32'(ctr_q[updateIdxE]), CTR_MAX));
        end else begin
            ctr_upd = CTR_W'(ctr_sat_dec(32'(ctr_q[updateIdxE])));
        end
    end

    // Counter array: train on every resolved branch
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_VAL;
            end
        end else if (updateValidE) begin
            ctr_q[updateIdxE] <= ctr_upd;
        end
    end

    // Mispredict statistics, sticking at all-ones
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mispred_cnt_q <= '0;
        end else if (mispredictE && (mispred_cnt_q != '1)) begin
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign mispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed scenarios followed by random
// traffic, compared against an arithmetic model of the predictor.
module tb_gshare_pht;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] lookupPcF;
    logic       lookupValidF;
    logic       predictTakenF;
    logic [2:0] lookupIdxF;
    logic [2:0] ghrSnapF;
    logic       updateValidE;
    logic [2:0] updateIdxE;
    logic [2:0] ghrSnapE;
    logic       branchTakenE;
    logic       branchPredictedE;
    logic       mispredictE;
    logic [15:0] mispredCount;

    // Second instance with a tiny statistics counter, sharing all inputs
    logic       predictTakenF2;
    logic [2:0] lookupIdxF2;
    logic [2:0] ghrSnapF2;
    logic       mispredictE2;
    logic [1:0] mispredCount2;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    int unsigned m_ctr [8];
    int unsigned m_ghr;
    int unsigned m_cnt;
    logic        pre_pred;

    always #5 clk = ~clk;

    gshare_pht dut (
        .clk              (clk),
        .reset            (reset),
        .lookupPcF        (lookupPcF),
        .lookupValidF     (lookupValidF),
        .predictTakenF    (predictTakenF),
        .lookupIdxF       (lookupIdxF),
        .ghrSnapF         (ghrSnapF),
        .updateValidE     (updateValidE),
        .updateIdxE       (updateIdxE),
        .ghrSnapE         (ghrSnapE),
        .branchTakenE     (branchTakenE),
        .branchPredictedE (branchPredictedE),
        .mispredictE      (mispredictE),
        .mispredCount     (mispredCount)
    );

    gshare_pht #(
        .CNT_W (2)
    ) dut_c2 (
        .clk              (clk),
        .reset            (reset),
        .lookupPcF        (lookupPcF),
        .lookupValidF     (lookupValidF),
        .predictTakenF    (predictTakenF2),
        .lookupIdxF       (lookupIdxF2),
        .ghrSnapF         (ghrSnapF2),
        .updateValidE     (updateValidE),
        .updateIdxE       (updateIdxE),
        .ghrSnapE         (ghrSnapE),
        .branchTakenE     (branchTakenE),
        .branchPredictedE (branchPredictedE),
        .mispredictE      (mispredictE2),
        .mispredCount     (mispredCount2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_ctr[i] = 1;
        m_ghr = 0;
        m_cnt = 0;
    endfunction

    function automatic int unsigned model_pred(input int unsigned idx);
        return (m_ctr[idx] >= 2) ? 1 : 0;
    endfunction

    // One full cycle: drive after posedge, check combinational outputs,
    // then check state after the falling edge.
    task automatic cycle(input logic [2:0] pc, input logic lv, input logic uv,
                         input logic [2:0] uidx, input logic [2:0] usnap,
                         input logic tk, input logic pr);
        int unsigned e_idx;
        int unsigned e_pred;
        int unsigned e_mis;
        @(posedge clk);
        #1;
        lookupPcF        = pc;
        lookupValidF     = lv;
        updateValidE     = uv;
        updateIdxE       = uidx;
        ghrSnapE         = usnap;
        branchTakenE     = tk;
        branchPredictedE = pr;
        #1;
        e_idx  = (32'(pc) ^ m_ghr) % 8;
        e_pred = model_pred(e_idx);
        e_mis  = (uv && (tk != pr)) ? 1 : 0;
        pre_pred = predictTakenF;
        chk("idx_pre", 32'(lookupIdxF), e_idx);
        chk("pred_pre", 32'(predictTakenF), e_pred);
        chk("snap_pre", 32'(ghrSnapF), m_ghr);
        chk("mispred", 32'(mispredictE), e_mis);
        @(negedge clk);
        if (uv) begin
            if (tk) m_ctr[uidx] = (m_ctr[uidx] == 3) ? 3 : m_ctr[uidx] + 1;
            else    m_ctr[uidx] = (m_ctr[uidx] == 0) ? 0 : m_ctr[uidx] - 1;
        end
        if (e_mis == 1) begin
            m_ghr = ((32'(usnap) * 2) + 32'(tk)) % 8;
            if (m_cnt < 65535) m_cnt++;
        end else if (lv) begin
            m_ghr = ((m_ghr * 2) + e_pred) % 8;
        end
        #1;
        chk("ghr", 32'(ghrSnapF), m_ghr);
        chk("cnt", 32'(mispredCount), m_cnt);
        chk("cnt2", 32'(mispredCount2), (m_cnt > 3) ? 3 : m_cnt);
        e_idx = (32'(pc) ^ m_ghr) % 8;
        chk("idx_post", 32'(lookupIdxF), e_idx);
        chk("pred_post", 32'(predictTakenF), model_pred(e_idx));
    endtask

    // Look up a chosen table entry without side effects, check its prediction
    task automatic probe(input string tag, input logic [2:0] idx, input logic exp);
        @(posedge clk);
        #1;
        lookupValidF = 1'b0;
        updateValidE = 1'b0;
        lookupPcF    = idx ^ 3'(m_ghr);
        #1;
        chk(tag, 32'(predictTakenF), 32'(exp));
    endtask

    // Reset pulse placed between edges
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset            = 1'b1;
        lookupPcF        = 3'd5;
        lookupValidF     = 1'b0;
        updateValidE     = 1'b0;
        updateIdxE       = 3'd0;
        ghrSnapE         = 3'd0;
        branchTakenE     = 1'b0;
        branchPredictedE = 1'b0;
        model_reset();

        // Reset values
        #3;
        chk("rst_pred", 32'(predictTakenF), 0);
        chk("rst_snap", 32'(ghrSnapF), 0);
        chk("rst_idx", 32'(lookupIdxF), 5);
        chk("rst_cnt", 32'(mispredCount), 0);
        chk("rst_mis", 32'(mispredictE), 0);
        #4;
        reset = 1'b0;

        // First mispredict trains idx5 and repairs history
        cycle(3'd5, 1'b0, 1'b1, 3'd5, 3'd0, 1'b1, 1'b0);
        chk("t2_ghr", 32'(ghrSnapF), 32'b001);
        chk("t2_cnt", 32'(mispredCount), 1);
        probe("t2_pred5", 3'd5, 1'b1);

        // Saturation both ways on idx2
        for (int i = 0; i < 4; i++) cycle(3'd0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1, 1'b1);
        probe("t3_sat_hi", 3'd2, 1'b1);
        cycle(3'd0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        probe("t3_from_top", 3'd2, 1'b1);
        for (int i = 0; i < 4; i++) cycle(3'd0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        probe("t3_sat_lo", 3'd2, 1'b0);
        cycle(3'd0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1, 1'b1);
        probe("t3_from_bot", 3'd2, 1'b0);

        // Speculative shifts 1,0,1 then repair beating a same-edge shift
        pulse_reset();
        cycle(3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
        cycle(3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cycle(3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cycle(3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("t4_ghr101", 32'(ghrSnapF), 32'b101);
        cycle(3'd1, 1'b1, 1'b1, 3'd6, 3'b010, 1'b0, 1'b1);
        chk("t4_ghr100", 32'(ghrSnapF), 32'b100);

        // Same-entry read and write: old value this cycle, new after the edge
        cycle(3'd0, 1'b0, 1'b1, 3'd4, 3'b100, 1'b1, 1'b1);
        chk("t5_pre", 32'(pre_pred), 0);
        chk("t5_post", 32'(predictTakenF), 1);

        // Count saturation in the narrow instance, then async clear
        for (int i = 0; i < 5; i++) cycle(3'd3, 1'b0, 1'b1, 3'd5, 3'd1, 1'b1, 1'b0);
        chk("t6_cnt2_sat", 32'(mispredCount2), 3);
        probe("t6_pred5_before", 3'd5, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_cnt", 32'(mispredCount), 0);
        chk("t6_rst_cnt2", 32'(mispredCount2), 0);
        chk("t6_rst_ghr", 32'(ghrSnapF), 0);
        lookupPcF = 3'd5;
        #1;
        chk("t6_rst_pred5", 32'(predictTakenF), 0);
        reset = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
